// File: rtl/abro_pkg.sv
// Shared A/B/O handshake definitions: order encodings, one-hot driver states, defaults.
package abro_pkg;

    typedef enum logic [1:0] {
        ORD_AB     = 2'b00,
        ORD_BA     = 2'b01,
        ORD_BOTH   = 2'b10,
        ORD_A_ONLY = 2'b11
    } order_e;

    localparam logic [5:0] ST_IDLE   = 6'b000001;
    localparam logic [5:0] ST_FIRST  = 6'b000010;
    localparam logic [5:0] ST_GAP    = 6'b000100;
    localparam logic [5:0] ST_SECOND = 6'b001000;
    localparam logic [5:0] ST_WAIT   = 6'b010000;
    localparam logic [5:0] ST_RESP   = 6'b100000;

    typedef enum logic [5:0] {
        StIdle   = ST_IDLE,
        StFirst  = ST_FIRST,
        StGap    = ST_GAP,
        StSecond = ST_SECOND,
        StWait   = ST_WAIT,
        StResp   = ST_RESP
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/abro_event_driver_if.sv
// Command, detector and response signals of the ABRO event driver.
interface abro_event_driver_if #(
    parameter int unsigned GAP_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_order;
    logic [GAP_W-1:0] cmd_gap;
    logic             A;
    logic             B;
    logic             O;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [7:0]       rsp_latency;
    logic             rsp_early;
    logic [5:0]       state;

    modport master (
        input  cmd_valid, cmd_order, cmd_gap, O, rsp_ready,
        output cmd_ready, A, B, rsp_valid, rsp_hit, rsp_latency, rsp_early, state
    );

    modport slave (
        output cmd_valid, cmd_order, cmd_gap, O, rsp_ready,
        input  cmd_ready, A, B, rsp_valid, rsp_hit, rsp_latency, rsp_early, state
    );
endinterface

// File: rtl/abro_wait_timer.sv
// Up-counter shared by GAP and WAIT: load to 1, count while enabled, done at limit.
module abro_wait_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(1);
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == i_limit);
endmodule

// File: rtl/abro_event_driver.sv
// ABRO initiator: pulses A/B per command, then times the detector's O response.
// Optional ABRO_DRV_EARLY_EN: sticky flag for O seen before the last event.
module abro_event_driver
    import abro_pkg::*;
#(
    parameter int unsigned GAP_W   = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                 clk,
    input logic                 reset_n,
    abro_event_driver_if.master bus
);
    localparam int unsigned CNT_W = (GAP_W > 8) ? GAP_W : 8;

    state_e           r_state;
    state_e           w_state_nxt;
    order_e           r_order;
    order_e           w_order;
    logic [GAP_W-1:0] r_gap;
    logic             r_a;
    logic             r_b;
    logic             w_a_nxt;
    logic             w_b_nxt;
    logic             r_hit;
    logic [7:0]       r_latency;
    logic             w_accept;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_limit;
    logic             w_done;

    assign w_accept = (r_state == StIdle) && bus.cmd_valid;
    // A/B flops load at the edge entering FIRST, before the order register is valid
    assign w_order  = (r_state == StIdle) ? order_e'(bus.cmd_order) : r_order;
    assign w_limit  = (r_state == StGap) ? CNT_W'(r_gap) : CNT_W'(TIMEOUT);

    abro_wait_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  ((r_state == StFirst) || (r_state == StSecond)),
        .i_en    ((r_state == StGap) || (r_state == StWait)),
        .i_limit (w_limit),
        .o_count (w_count),
        .o_done  (w_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (bus.cmd_valid) w_state_nxt = StFirst;
            StFirst: begin
                if ((r_order == ORD_BOTH) || (r_order == ORD_A_ONLY)) w_state_nxt = StWait;
                else if (r_gap != '0)                                  w_state_nxt = StGap;
                else                                                   w_state_nxt = StSecond;
            end
            StGap:    if (w_done) w_state_nxt = StSecond;
            StSecond: w_state_nxt = StWait;
            StWait:   if (bus.O || w_done) w_state_nxt = StResp;
            StResp:   if (bus.rsp_ready) w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_a_nxt = 1'b0;
        w_b_nxt = 1'b0;
        if (w_state_nxt == StFirst) begin
            w_a_nxt = (w_order != ORD_BA);
            w_b_nxt = (w_order == ORD_BA) || (w_order == ORD_BOTH);
        end else if (w_state_nxt == StSecond) begin
            w_a_nxt = (w_order == ORD_BA);
            w_b_nxt = (w_order == ORD_AB);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_order   <= ORD_AB;
            r_gap     <= '0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_hit     <= 1'b0;
            r_latency <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            if (w_accept) begin
                r_order <= order_e'(bus.cmd_order);
                r_gap   <= bus.cmd_gap;
            end
            if ((r_state == StWait) && (bus.O || w_done)) begin
                r_hit     <= bus.O;
                r_latency <= bus.O ? sat8(32'(w_count)) : sat8(32'(TIMEOUT));
            end
        end
    end

`ifdef ABRO_DRV_EARLY_EN
    logic r_early;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_early <= 1'b0;
        end else if (w_accept) begin
            r_early <= 1'b0;
        end else if (bus.O && ((r_state == StFirst) || (r_state == StGap)
                               || (r_state == StSecond))) begin
            r_early <= 1'b1;
        end
    end

    assign bus.rsp_early = r_early;
`else
    assign bus.rsp_early = 1'b0;
`endif

    assign bus.cmd_ready   = (r_state == StIdle);
    assign bus.rsp_valid   = (r_state == StResp);
    assign bus.rsp_hit     = r_hit;
    assign bus.rsp_latency = r_latency;
    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_abro_event_driver.sv
// Scoreboarded bench for abro_event_driver with a small registered ABRO detector model.
module tb_abro_event_driver;
    import abro_pkg::*;

    localparam int unsigned TB_TIMEOUT = 16;

    typedef struct packed {
        logic       hit;
        logic [7:0] lat;
        logic       early;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic det_sa, det_sb, det_o, det_clr, o_force;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    abro_event_driver_if #(.GAP_W(8)) bus ();

    abro_event_driver #(
        .GAP_W   (8),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Detector: O pulses one cycle after both A and B have been seen
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_sa <= 1'b0;
            det_sb <= 1'b0;
            det_o  <= 1'b0;
        end else if (det_clr) begin
            det_sa <= 1'b0;
            det_sb <= 1'b0;
            det_o  <= 1'b0;
        end else begin
            det_sa <= det_sa | bus.A;
            det_sb <= det_sb | bus.B;
            det_o  <= (det_sa | bus.A) & (det_sb | bus.B) & ~(det_sa & det_sb);
        end
    end

    assign bus.O = o_force | det_o;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] ord, input logic [7:0] gap, input int hold,
                           input bit force_gap);
        exp_t e;
        exp_t g;
        int   a_idx, b_idx, a_cnt, b_cnt, wait_cnt, idx, viol;
        bit   ok;
        bit   done;

        det_clr = 1'b1;
        @(negedge clk);
        det_clr = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1'b1;
            else @(negedge clk);
        end
        check_eq("cmd_ready_wait", 32'(ok), 1);
        if (!ok) return;

        bus.cmd_valid = 1'b1;
        bus.cmd_order = ord;
        bus.cmd_gap   = gap;
        e.hit = (ord != 2'(ORD_A_ONLY));
        e.lat = e.hit ? 8'd1 : 8'(TB_TIMEOUT);
`ifdef ABRO_DRV_EARLY_EN
        e.early = force_gap;
`else
        e.early = 1'b0;
`endif
        sb_q.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check_eq("first_state", 32'(bus.state), 32'(ST_FIRST));
        check_eq("first_not_ready", 32'(bus.cmd_ready), 0);

        a_idx = -1; b_idx = -1; a_cnt = 0; b_cnt = 0; wait_cnt = 0; idx = 0; viol = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (bus.rsp_valid) begin
                done = 1'b1;
            end else begin
                if (bus.A) begin a_cnt++; if (a_idx < 0) a_idx = idx; end
                if (bus.B) begin b_cnt++; if (b_idx < 0) b_idx = idx; end
                if ((bus.A || bus.B) && (bus.state != ST_FIRST) && (bus.state != ST_SECOND))
                    viol++;
                if (bus.state == ST_WAIT) wait_cnt++;
                if (force_gap) o_force = (bus.state == ST_GAP);
                idx++;
                @(negedge clk);
            end
        end
        o_force = 1'b0;
        check_eq("rsp_seen", 32'(done), 1);
        g = sb_q.pop_front();
        if (!done) return;

        check_eq("rsp_hit", 32'(bus.rsp_hit), 32'(g.hit));
        check_eq("rsp_latency", 32'(bus.rsp_latency), 32'(g.lat));
        check_eq("rsp_early", 32'(bus.rsp_early), 32'(g.early));
        check_eq("wait_cycles", 32'(wait_cnt), 32'(g.lat));
        check_eq("a_count", 32'(a_cnt), 1);
        check_eq("b_count", 32'(b_cnt), (ord == 2'(ORD_A_ONLY)) ? 0 : 1);
        check_eq("first_event_idx", 32'((ord == 2'(ORD_BA)) ? b_idx : a_idx), 0);
        case (ord)
            2'b00:   check_eq("spacing_ab", 32'(b_idx - a_idx), 32'(gap) + 1);
            2'b01:   check_eq("spacing_ba", 32'(a_idx - b_idx), 32'(gap) + 1);
            2'b10:   check_eq("spacing_both", 32'(b_idx - a_idx), 0);
            default: ;
        endcase
        check_eq("ab_outside_events", 32'(viol), 0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.rsp_valid), 1);
            check_eq("hold_hit", 32'(bus.rsp_hit), 32'(g.hit));
            check_eq("hold_latency", 32'(bus.rsp_latency), 32'(g.lat));
            check_eq("hold_not_ready", 32'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq("post_rsp_state", 32'(bus.state), 32'(ST_IDLE));
        check_eq("post_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("post_rsp_ready", 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        det_clr       = 1'b0;
        o_force       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_order = 2'b00;
        bus.cmd_gap   = 8'd0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_state", 32'(bus.state), 32'(ST_IDLE));
        check_eq("rst_ab", 32'({bus.A, bus.B}), 0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_rsp_fields", 32'({bus.rsp_hit, bus.rsp_early, bus.rsp_latency}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 1);

        run_cmd(2'b00, 8'd0, 0, 1'b0);
        run_cmd(2'b01, 8'd3, 0, 1'b0);
        run_cmd(2'b11, 8'd0, 0, 1'b0);
        run_cmd(2'b10, 8'd0, 5, 1'b0);
        run_cmd(2'b00, 8'd4, 0, 1'b1);
        run_cmd(2'b01, 8'd2, 0, 1'b0);

        // Abort mid-GAP: no response must follow
        bus.cmd_valid = 1'b1;
        bus.cmd_order = 2'b00;
        bus.cmd_gap   = 8'd5;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 10 && (bus.state != ST_GAP); i++) @(negedge clk);
        check_eq("reached_gap", 32'(bus.state), 32'(ST_GAP));
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("abort_state", 32'(bus.state), 32'(ST_IDLE));
        check_eq("abort_ab", 32'({bus.A, bus.B}), 0);
        check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("abort_no_rsp", 32'(bus.rsp_valid), 0);
        run_cmd(2'b00, 8'd1, 2, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)), $urandom_range(0, 3),
                    1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
